// File: rtl/game_fsm_pkg.sv
// Shared types and helpers for the 1A2B game controller: state encoding,
// digit-word type and the A/B scoring / digit-usage helpers.
package game_types;

    localparam int C_NUM_DIGITS = 4;

    typedef enum logic [3:0] {
        S_IDLE        = 4'd0,
        S_SET_D3      = 4'd1,
        S_SET_D2      = 4'd2,
        S_SET_D1      = 4'd3,
        S_SET_D0      = 4'd4,
        S_GUESS_D3    = 4'd5,
        S_GUESS_D2    = 4'd6,
        S_GUESS_D1    = 4'd7,
        S_GUESS_D0    = 4'd8,
        S_SHOW_RESULT = 4'd9,
        S_WIN         = 4'd10,
        S_LOSE        = 4'd11
    } state_t;

    typedef logic [C_NUM_DIGITS-1:0] [3:0] digit_arr_t;

    // Digit position being edited; non-editing states report 3 so nothing counts as used.
    function automatic logic [1:0] state_pos(input state_t s);
        logic [1:0] p;
        case (s)
            S_SET_D2, S_GUESS_D2: p = 2'd2;
            S_SET_D1, S_GUESS_D1: p = 2'd1;
            S_SET_D0, S_GUESS_D0: p = 2'd0;
            default:              p = 2'd3;
        endcase
        return p;
    endfunction

    function automatic state_t next_state(input state_t s);
        state_t n;
        case (s)
            S_SET_D3:   n = S_SET_D2;
            S_SET_D2:   n = S_SET_D1;
            S_SET_D1:   n = S_SET_D0;
            S_SET_D0:   n = S_GUESS_D3;
            S_GUESS_D3: n = S_GUESS_D2;
            S_GUESS_D2: n = S_GUESS_D1;
            S_GUESS_D1: n = S_GUESS_D0;
            S_GUESS_D0: n = S_SHOW_RESULT;
            default:    n = S_IDLE;
        endcase
        return n;
    endfunction

    // True when digit d already sits at a position above pos in word w.
    function automatic logic digit_used(input digit_arr_t w, input logic [1:0] pos,
                                        input logic [3:0] d);
        logic hit;
        hit = 1'b0;
        for (int j = 0; j < C_NUM_DIGITS; j++) begin
            if ((j > int'(pos)) && (w[j] == d)) begin
                hit = 1'b1;
            end
        end
        return hit;
    endfunction

    function automatic logic [2:0] score_a(input digit_arr_t t, input digit_arr_t g);
        logic [2:0] n;
        n = 3'd0;
        for (int i = 0; i < C_NUM_DIGITS; i++) begin
            if (g[i] == t[i]) begin
                n = n + 3'd1;
            end
        end
        return n;
    endfunction

    function automatic logic [2:0] score_b(input digit_arr_t t, input digit_arr_t g);
        logic [2:0] n;
        n = 3'd0;
        for (int i = 0; i < C_NUM_DIGITS; i++) begin
            for (int j = 0; j < C_NUM_DIGITS; j++) begin
                if ((i != j) && (g[i] == t[j])) begin
                    n = n + 3'd1;
                end
            end
        end
        return n;
    endfunction

endpackage

// File: rtl/game_fsm_lfsr16.sv
// Free-running 16-bit maximal-length LFSR (x^16+x^14+x^13+x^11+1), seeded
// with 16'hACE1 so it can never lock up in the all-zero state.
module lfsr16 (
    input  logic        clk,
    input  logic        rst_n,
    output logic [15:0] value
);

    logic feedback;

    assign feedback = value[0] ^ value[2] ^ value[3] ^ value[5];

    // Right-shifting Fibonacci form, feedback enters at the MSB.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            value <= 16'hACE1;
        end else begin
            value <= {feedback, value[15:1]};
        end
    end

endmodule

// File: rtl/game_fsm.sv
// 1A2B game sequencing controller. Optional per-guess time limit is enabled
// by defining GAME_GUESS_TIMEOUT_EN.
module game_fsm
    import game_types::*;
#(
    parameter int MAX_CHANCES = 5,
    parameter int BLINK_DIV   = 25_000_000,
    parameter int TIMEOUT_CYC = 500_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] sw,
    input  logic       btn_confirm,
    input  logic       btn_random,
    input  logic       btn_abort,
    output state_t     state,
    output digit_arr_t target,
    output digit_arr_t guess,
    output logic [3:0] candidate,
    output logic       sw_valid,
    output logic [2:0] chances,
    output logic [3:0] is_random,
    output logic [2:0] a_cnt,
    output logic [2:0] b_cnt,
    output logic       blink_on
);

    localparam logic [2:0]  C_MAX_CH     = 3'(MAX_CHANCES);
    localparam logic [31:0] C_BLINK_LAST = 32'(BLINK_DIV - 1);

    logic [15:0] lfsr_val;
    logic        rnd_pend;
    logic [31:0] blink_cnt;
    logic [3:0]  sw_idx;
    logic [1:0]  pos;
    logic        in_set;
    logic        in_guess;
    digit_arr_t  word;
    digit_arr_t  guess_final;
    logic [3:0]  rnd_digit;
    logic        rnd_ok;
    logic        timeout_hit;

    lfsr16 u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .value (lfsr_val)
    );

    // Switch decode, duplicate-digit screening and the word as it will look after a D0 commit.
    always_comb begin
        sw_idx = 4'd0;
        for (int i = 0; i < 10; i++) begin
            if (sw[i]) begin
                sw_idx = 4'(i);
            end else begin
                sw_idx = sw_idx;
            end
        end
        in_set   = (state == S_SET_D3) || (state == S_SET_D2) ||
                   (state == S_SET_D1) || (state == S_SET_D0);
        in_guess = (state == S_GUESS_D3) || (state == S_GUESS_D2) ||
                   (state == S_GUESS_D1) || (state == S_GUESS_D0);
        pos = state_pos(state);
        if (in_set) begin
            word = target;
        end else if (in_guess) begin
            word = guess;
        end else begin
            word = '0;
        end
        sw_valid    = $onehot(sw) && !digit_used(word, pos, sw_idx);
        candidate   = sw_valid ? sw_idx : 4'd0;
        rnd_digit   = lfsr_val[3:0];
        rnd_ok      = (rnd_digit < 4'd10) && !digit_used(target, pos, rnd_digit);
        guess_final = guess;
        guess_final[0] = candidate;
    end

`ifdef GAME_GUESS_TIMEOUT_EN
    logic [31:0] t_cnt;

    assign timeout_hit = in_guess && (t_cnt == 32'(TIMEOUT_CYC - 1));

    // Per-digit timer: restarts outside guessing, on every accepted digit and on expiry.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            t_cnt <= 32'd0;
        end else if (btn_abort || !in_guess || timeout_hit || (btn_confirm && sw_valid)) begin
            t_cnt <= 32'd0;
        end else begin
            t_cnt <= t_cnt + 32'd1;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // Free-running blink generator, independent of the game state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            blink_cnt <= 32'd0;
            blink_on  <= 1'b0;
        end else if (blink_cnt >= C_BLINK_LAST) begin
            blink_cnt <= 32'd0;
            blink_on  <= ~blink_on;
        end else begin
            blink_cnt <= blink_cnt + 32'd1;
        end
    end

    // Game sequencer: abort beats an expired guess timer, which beats the keys.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            target    <= '0;
            guess     <= '0;
            is_random <= 4'd0;
            chances   <= 3'd0;
            a_cnt     <= 3'd0;
            b_cnt     <= 3'd0;
            rnd_pend  <= 1'b0;
        end else if (btn_abort) begin
            state    <= S_IDLE;
            rnd_pend <= 1'b0;
        end else if (timeout_hit) begin
            guess <= '0;
            if (chances <= 3'd1) begin
                chances <= 3'd0;
                state   <= S_LOSE;
            end else begin
                chances <= chances - 3'd1;
                state   <= S_GUESS_D3;
            end
        end else begin
            case (state)
                S_IDLE: begin
                    if (btn_confirm) begin
                        target    <= '0;
                        guess     <= '0;
                        is_random <= 4'd0;
                        chances   <= C_MAX_CH;
                        state     <= S_SET_D3;
                    end
                end
                S_SET_D3, S_SET_D2, S_SET_D1, S_SET_D0: begin
                    // A pending random draw retries every cycle and locks out confirm.
                    if (rnd_pend) begin
                        if (rnd_ok) begin
                            target[pos]    <= rnd_digit;
                            is_random[pos] <= 1'b1;
                            rnd_pend       <= 1'b0;
                            state          <= next_state(state);
                        end
                    end else if (btn_confirm) begin
                        if (sw_valid) begin
                            target[pos]    <= candidate;
                            is_random[pos] <= 1'b0;
                            state          <= next_state(state);
                        end
                    end else if (btn_random) begin
                        rnd_pend <= 1'b1;
                    end
                end
                S_GUESS_D3, S_GUESS_D2, S_GUESS_D1: begin
                    if (btn_confirm && sw_valid) begin
                        guess[pos] <= candidate;
                        state      <= next_state(state);
                    end
                end
                S_GUESS_D0: begin
                    if (btn_confirm && sw_valid) begin
                        guess[0] <= candidate;
                        a_cnt    <= score_a(target, guess_final);
                        b_cnt    <= score_b(target, guess_final);
                        state    <= S_SHOW_RESULT;
                    end
                end
                S_SHOW_RESULT: begin
                    if (btn_confirm) begin
                        if (a_cnt == 3'd4) begin
                            state <= S_WIN;
                        end else if (chances <= 3'd1) begin
                            chances <= 3'd0;
                            state   <= S_LOSE;
                        end else begin
                            chances <= chances - 3'd1;
                            guess   <= '0;
                            state   <= S_GUESS_D3;
                        end
                    end
                end
                S_WIN, S_LOSE: begin
                    if (btn_confirm) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_game_fsm.sv
// Scoreboard bench for game_fsm: a phase/position reference model predicts
// every cycle's outputs; a monitor process compares them after each edge.
module tb_game_fsm;
    import game_types::*;

    localparam int MAXC = 5;
    localparam int BDIV = 6;
    localparam int TOUT = 100;
    localparam int P_IDLE = 0, P_SET = 1, P_GUESS = 2, P_SHOW = 3, P_WIN = 4, P_LOSE = 5;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [9:0] sw = 10'd0;
    logic       btn_confirm = 1'b0;
    logic       btn_random = 1'b0;
    logic       btn_abort = 1'b0;
    state_t     state;
    digit_arr_t target, guess;
    logic [3:0] candidate, is_random;
    logic       sw_valid, blink_on;
    logic [2:0] chances, a_cnt, b_cnt;

    game_fsm #(.MAX_CHANCES(MAXC), .BLINK_DIV(BDIV), .TIMEOUT_CYC(TOUT)) dut (
        .clk(clk), .rst_n(rst_n), .sw(sw), .btn_confirm(btn_confirm),
        .btn_random(btn_random), .btn_abort(btn_abort), .state(state),
        .target(target), .guess(guess), .candidate(candidate), .sw_valid(sw_valid),
        .chances(chances), .is_random(is_random), .a_cnt(a_cnt), .b_cnt(b_cnt),
        .blink_on(blink_on)
    );

    always #5 clk = ~clk;

    typedef struct {
        state_t     st;
        digit_arr_t tg;
        digit_arr_t gs;
        logic [3:0] isr;
        logic [2:0] ch;
        logic [2:0] a;
        logic [2:0] b;
        logic       bl;
        logic       sv;
        logic [3:0] cand;
    } exp_t;

    exp_t exp_q[$];
    int checks = 0;
    int failures = 0;

    // Reference model state
    int m_phase, m_pos, m_ch, m_a, m_b, m_bcnt, m_tcnt;
    int m_tgt[4];
    int m_gs[4];
    bit m_isr[4];
    bit m_pend, m_blink;
    logic [15:0] m_lfsr;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, req, $time);
        end
    endtask

    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return {v[0] ^ v[2] ^ v[3] ^ v[5], v[15:1]};
    endfunction

    function automatic logic [9:0] oh(input int d);
        logic [9:0] v;
        v = 10'd1 << d;
        return v;
    endfunction

    function automatic bit used_in(input int w[4], input int p, input int d);
        for (int j = p + 1; j < 4; j++) if (w[j] == d) return 1'b1;
        return 1'b0;
    endfunction

    // Is the switch pattern acceptable in the model's current state; also yields the digit.
    function automatic bit model_valid(input logic [9:0] s, output int cand);
        int idx;
        bit ok;
        idx = 0;
        for (int i = 0; i < 10; i++) if (s[i]) idx = i;
        ok = ($countones(s) == 1);
        if (ok && m_phase == P_SET) ok = !used_in(m_tgt, m_pos, idx);
        if (ok && m_phase == P_GUESS) ok = !used_in(m_gs, m_pos, idx);
        cand = ok ? idx : 0;
        return ok;
    endfunction

    function automatic state_t to_state(input int ph, input int p);
        case (ph)
            P_SET:   return (p == 3) ? S_SET_D3 : (p == 2) ? S_SET_D2 : (p == 1) ? S_SET_D1 : S_SET_D0;
            P_GUESS: return (p == 3) ? S_GUESS_D3 : (p == 2) ? S_GUESS_D2 : (p == 1) ? S_GUESS_D1 : S_GUESS_D0;
            P_SHOW:  return S_SHOW_RESULT;
            P_WIN:   return S_WIN;
            P_LOSE:  return S_LOSE;
            default: return S_IDLE;
        endcase
    endfunction

    task automatic push_expected(input logic [9:0] s);
        exp_t e;
        int c;
        e.st = to_state(m_phase, m_pos);
        for (int i = 0; i < 4; i++) begin
            e.tg[i]  = 4'(m_tgt[i]);
            e.gs[i]  = 4'(m_gs[i]);
            e.isr[i] = m_isr[i];
        end
        e.ch = 3'(m_ch);
        e.a  = 3'(m_a);
        e.b  = 3'(m_b);
        e.bl = m_blink;
        e.sv = model_valid(s, c);
        e.cand = 4'(c);
        exp_q.push_back(e);
    endtask

    task automatic model_reset(input logic [9:0] s);
        m_phase = P_IDLE; m_pos = 3; m_ch = 0; m_a = 0; m_b = 0;
        m_bcnt = 0; m_tcnt = 0; m_pend = 1'b0; m_blink = 1'b0; m_lfsr = 16'hACE1;
        for (int i = 0; i < 4; i++) begin m_tgt[i] = 0; m_gs[i] = 0; m_isr[i] = 1'b0; end
        push_expected(s);
    endtask

    task automatic wipe_guess();
        for (int i = 0; i < 4; i++) m_gs[i] = 0;
    endtask

    task automatic model_step(input logic [9:0] s, input bit c, input bit r, input bit a);
        int r4, cand, pre_phase;
        bit val, expired, accepted;
        r4 = int'(m_lfsr[3:0]);
        m_lfsr = lfsr_next(m_lfsr);
        if (m_bcnt == BDIV - 1) begin m_bcnt = 0; m_blink = !m_blink; end
        else m_bcnt++;
        val = model_valid(s, cand);
        pre_phase = m_phase;
        accepted = 1'b0;
        expired = 1'b0;
`ifdef GAME_GUESS_TIMEOUT_EN
        expired = (m_phase == P_GUESS) && (m_tcnt == TOUT - 1);
`endif
        if (a) begin
            m_phase = P_IDLE; m_pend = 1'b0;
        end else if (expired) begin
            wipe_guess();
            if (m_ch <= 1) begin m_ch = 0; m_phase = P_LOSE; end
            else begin m_ch--; m_pos = 3; end
        end else begin
            case (m_phase)
                P_IDLE: if (c) begin
                    for (int i = 0; i < 4; i++) begin m_tgt[i] = 0; m_gs[i] = 0; m_isr[i] = 1'b0; end
                    m_ch = MAXC; m_phase = P_SET; m_pos = 3;
                end
                P_SET: begin
                    if (m_pend) begin
                        if (r4 < 10 && !used_in(m_tgt, m_pos, r4)) begin
                            m_tgt[m_pos] = r4; m_isr[m_pos] = 1'b1; m_pend = 1'b0;
                            if (m_pos == 0) begin m_phase = P_GUESS; m_pos = 3; end else m_pos--;
                        end
                    end else if (c) begin
                        if (val) begin
                            m_tgt[m_pos] = cand; m_isr[m_pos] = 1'b0;
                            if (m_pos == 0) begin m_phase = P_GUESS; m_pos = 3; end else m_pos--;
                        end
                    end else if (r) m_pend = 1'b1;
                end
                P_GUESS: if (c && val) begin
                    m_gs[m_pos] = cand; accepted = 1'b1;
                    if (m_pos == 0) begin
                        m_phase = P_SHOW; m_a = 0; m_b = 0;
                        for (int i = 0; i < 4; i++)
                            for (int j = 0; j < 4; j++)
                                if (m_gs[i] == m_tgt[j]) begin
                                    if (i == j) m_a++; else m_b++;
                                end
                    end else m_pos--;
                end
                P_SHOW: if (c) begin
                    if (m_a == 4) m_phase = P_WIN;
                    else if (m_ch <= 1) begin m_ch = 0; m_phase = P_LOSE; end
                    else begin m_ch--; wipe_guess(); m_phase = P_GUESS; m_pos = 3; end
                end
                default: if (c) m_phase = P_IDLE;
            endcase
        end
        if (!a && pre_phase == P_GUESS && !expired && !accepted) m_tcnt++;
        else m_tcnt = 0;
        push_expected(s);
    endtask

    task automatic cycle(input logic [9:0] s, input bit c, input bit r, input bit a);
        @(negedge clk);
        sw = s; btn_confirm = c; btn_random = r; btn_abort = a; rst_n = 1'b1;
        model_step(s, c, r, a);
        @(posedge clk);
        #2;
    endtask

    task automatic reset_cycle();
        @(negedge clk);
        rst_n = 1'b0; sw = 10'd0; btn_confirm = 1'b0; btn_random = 1'b0; btn_abort = 1'b0;
        model_reset(10'd0);
        @(posedge clk);
        #2;
    endtask

    task automatic enter_word(input int d3, input int d2, input int d1, input int d0);
        cycle(oh(d3), 1'b1, 1'b0, 1'b0);
        cycle(oh(d2), 1'b1, 1'b0, 1'b0);
        cycle(oh(d1), 1'b1, 1'b0, 1'b0);
        cycle(oh(d0), 1'b1, 1'b0, 1'b0);
    endtask

    // Monitor: every edge yields one predicted output set, compared just after the edge.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("state", 32'(state), 32'(e.st));
            chk("target", 32'(target), 32'(e.tg));
            chk("guess", 32'(guess), 32'(e.gs));
            chk("is_random", 32'(is_random), 32'(e.isr));
            chk("chances", 32'(chances), 32'(e.ch));
            chk("a_cnt", 32'(a_cnt), 32'(e.a));
            chk("b_cnt", 32'(b_cnt), 32'(e.b));
            chk("blink_on", 32'(blink_on), 32'(e.bl));
            chk("sw_valid", 32'(sw_valid), 32'(e.sv));
            chk("candidate", 32'(candidate), 32'(e.cand));
        end
    end

    initial begin
        logic [15:0] n1, n2;
        int guard, k;
        logic [9:0] s;
        bit c, r, a;

        reset_cycle();
        reset_cycle();
        chk("rst_state", 32'(state), 32'(S_IDLE));
        chk("rst_chances", 32'(chances), 32'd0);
        chk("rst_sw_valid", 32'(sw_valid), 32'd0);
        for (int i = 0; i < BDIV - 1; i++) cycle(10'd0, 1'b0, 1'b0, 1'b0);
        chk("blink_before_div", 32'(blink_on), 32'd0);
        cycle(10'd0, 1'b0, 1'b0, 1'b0);
        chk("blink_after_div", 32'(blink_on), 32'd1);

        // Manual target 1234, with a duplicate-digit probe in S_SET_D2.
        cycle(10'd0, 1'b1, 1'b0, 1'b0);
        cycle(oh(1), 1'b1, 1'b0, 1'b0);
        cycle(10'b0000000010, 1'b0, 1'b0, 1'b0);
        chk("dup_sw_valid", 32'(sw_valid), 32'd0);
        cycle(oh(2), 1'b1, 1'b0, 1'b0);
        cycle(oh(3), 1'b1, 1'b0, 1'b0);
        cycle(oh(4), 1'b1, 1'b0, 1'b0);
        chk("set_done_state", 32'(state), 32'(S_GUESS_D3));
        chk("set_done_isr", 32'(is_random), 32'd0);

        enter_word(1, 2, 4, 3);
        chk("score_a_1243", 32'(a_cnt), 32'd2);
        chk("score_b_1243", 32'(b_cnt), 32'd2);
        cycle(10'd0, 1'b1, 1'b0, 1'b0);
        chk("retry_chances", 32'(chances), 32'd4);
        chk("retry_state", 32'(state), 32'(S_GUESS_D3));

        // Fresh game: five wrong guesses lose.
        cycle(10'd0, 1'b0, 1'b0, 1'b1);
        cycle(10'd0, 1'b1, 1'b0, 1'b0);
        enter_word(1, 2, 3, 4);
        for (int g = 0; g < MAXC; g++) begin
            enter_word(5, 6, 7, 8);
            cycle(10'd0, 1'b1, 1'b0, 1'b0);
        end
        chk("lose_state", 32'(state), 32'(S_LOSE));
        chk("lose_chances", 32'(chances), 32'd0);

        // Next game: right on the first try.
        cycle(10'd0, 1'b1, 1'b0, 1'b0);
        cycle(10'd0, 1'b1, 1'b0, 1'b0);
        enter_word(1, 2, 3, 4);
        enter_word(1, 2, 3, 4);
        chk("win_a", 32'(a_cnt), 32'd4);
        cycle(10'd0, 1'b1, 1'b0, 1'b0);
        chk("win_state", 32'(state), 32'(S_WIN));

        // Abort beats confirm in S_GUESS_D1.
        cycle(10'd0, 1'b1, 1'b0, 1'b0);
        cycle(10'd0, 1'b1, 1'b0, 1'b0);
        enter_word(1, 2, 3, 4);
        cycle(oh(1), 1'b1, 1'b0, 1'b0);
        cycle(oh(2), 1'b1, 1'b0, 1'b0);
        chk("pre_abort_state", 32'(state), 32'(S_GUESS_D1));
        cycle(oh(3), 1'b1, 1'b0, 1'b1);
        chk("abort_state", 32'(state), 32'(S_IDLE));

        // Random draw in S_SET_D3: wait until the draw needs exactly one retry.
        cycle(10'd0, 1'b1, 1'b0, 1'b0);
        guard = 0;
        n1 = lfsr_next(m_lfsr);
        n2 = lfsr_next(n1);
        while (!(n1[3:0] >= 4'd10 && n2[3:0] < 4'd10) && guard < 2000) begin
            cycle(10'd0, 1'b0, 1'b0, 1'b0);
            n1 = lfsr_next(m_lfsr);
            n2 = lfsr_next(n1);
            guard++;
        end
        cycle(10'd0, 1'b0, 1'b1, 1'b0);
        cycle(10'd0, 1'b0, 1'b0, 1'b0);
        chk("rnd_retry_state", 32'(state), 32'(S_SET_D3));
        cycle(10'd0, 1'b0, 1'b0, 1'b0);
        chk("rnd_state", 32'(state), 32'(S_SET_D2));
        chk("rnd_digit", 32'(target[3]), 32'(n2[3:0]));
        chk("rnd_flag", 32'(is_random[3]), 32'd1);

`ifdef GAME_GUESS_TIMEOUT_EN
        cycle(10'd0, 1'b0, 1'b0, 1'b1);
        cycle(10'd0, 1'b1, 1'b0, 1'b0);
        enter_word(1, 2, 3, 4);
        for (int i = 0; i < TOUT - 1; i++) cycle(10'd0, 1'b0, 1'b0, 1'b0);
        chk("tout_pre_chances", 32'(chances), 32'(MAXC));
        cycle(10'd0, 1'b0, 1'b0, 1'b0);
        chk("tout_chances", 32'(chances), 32'(MAXC - 1));
        chk("tout_state", 32'(state), 32'(S_GUESS_D3));
`endif

        // Randomized play against the model.
        for (int n = 0; n < 4000; n++) begin
            k = $urandom_range(0, 99);
            if (k < 75) s = oh($urandom_range(0, 9));
            else s = 10'($urandom);
            k = $urandom_range(0, 99);
            c = (k < 35);
            r = (k >= 35) && (k < 50);
            a = ($urandom_range(0, 99) < 2);
            cycle(s, c, r, a);
        end

        guard = 0;
        while (exp_q.size() > 0 && guard < 20) begin
            @(posedge clk);
            #2;
            guard++;
        end
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
